// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder.
//   SEG7_0..SEG7_F : active-high glyphs, bit 0 = segment a .. bit 6 = segment g
//   SEG_DP_BIT     : position of the decimal point in the 8-bit segment bus
//   state_e        : capture FSM state encoding
package seg7_pkg;

    localparam logic [6:0] SEG7_0 = 7'h3F;
    localparam logic [6:0] SEG7_1 = 7'h06;
    localparam logic [6:0] SEG7_2 = 7'h5B;
    localparam logic [6:0] SEG7_3 = 7'h4F;
    localparam logic [6:0] SEG7_4 = 7'h66;
    localparam logic [6:0] SEG7_5 = 7'h6D;
    localparam logic [6:0] SEG7_6 = 7'h7D;
    localparam logic [6:0] SEG7_7 = 7'h07;
    localparam logic [6:0] SEG7_8 = 7'h7F;
    localparam logic [6:0] SEG7_9 = 7'h6F;
    localparam logic [6:0] SEG7_A = 7'h77;
    localparam logic [6:0] SEG7_B = 7'h7C;
    localparam logic [6:0] SEG7_C = 7'h39;
    localparam logic [6:0] SEG7_D = 7'h5E;
    localparam logic [6:0] SEG7_E = 7'h79;
    localparam logic [6:0] SEG7_F = 7'h71;

    localparam int unsigned SEG_DP_BIT = 7;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StHold
    } state_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus bundle between a scanned 7-segment driver/monitor and seg_scan_decoder.
//   seg, en, clear            : driven by the master (scan source / bench)
//   digits, dp, digit_valid,
//   frame_stb, err_pattern,
//   err_enable                : driven by the slave (decoder)
interface seg_scan_decoder_if #(
    parameter int unsigned NDIG = 3
);
    logic [7:0]        seg;
    logic [NDIG-1:0]   en;
    logic              clear;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   digit_valid;
    logic              frame_stb;
    logic              err_pattern;
    logic              err_enable;

    modport master (
        output seg, en, clear,
        input  digits, dp, digit_valid, frame_stb, err_pattern, err_enable
    );

    modport slave (
        input  seg, en, clear,
        output digits, dp, digit_valid, frame_stb, err_pattern, err_enable
    );
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment glyph decoder.
//   pat_i    : active-high segments, bit 0 = a .. bit 6 = g
//   legal_o  : 1 when pat_i is one of the 16 hex glyphs
//   nibble_o : decoded value (0 when illegal)
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic       legal_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        legal_o  = 1'b1;
        nibble_o = 4'h0;
        case (pat_i)
            SEG7_0:  nibble_o = 4'h0;
            SEG7_1:  nibble_o = 4'h1;
            SEG7_2:  nibble_o = 4'h2;
            SEG7_3:  nibble_o = 4'h3;
            SEG7_4:  nibble_o = 4'h4;
            SEG7_5:  nibble_o = 4'h5;
            SEG7_6:  nibble_o = 4'h6;
            SEG7_7:  nibble_o = 4'h7;
            SEG7_8:  nibble_o = 4'h8;
            SEG7_9:  nibble_o = 4'h9;
            SEG7_A:  nibble_o = 4'hA;
            SEG7_B:  nibble_o = 4'hB;
            SEG7_C:  nibble_o = 4'hC;
            SEG7_D:  nibble_o = 4'hD;
            SEG7_E:  nibble_o = 4'hE;
            SEG7_F:  nibble_o = 4'hF;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: synchronises seg/en, waits for each selected
// digit to settle, decodes the glyph and keeps the latest nibble/dp per digit.
//   cin, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of seg_scan_decoder_if (seg/en/clear in; digits, dp, digit_valid,
//                frame_stb, err_pattern, err_enable out)
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG          = 3,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter bit          SEG_ACT_LOW   = 1'b1,
    parameter bit          EN_ACT_LOW    = 1'b1
) (
    input  logic                cin,
    input  logic                rst_n,
    seg_scan_decoder_if.slave   bus
);

    localparam int unsigned     CntW    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntSat  = CntW'(SETTLE_CYCLES);
    // Raw bus levels meaning "nothing lit / nothing selected"; XOR with them normalises.
    localparam logic [7:0]      SegIdle = {8{SEG_ACT_LOW}};
    localparam logic [NDIG-1:0] EnIdle  = {NDIG{EN_ACT_LOW}};

    logic [7:0]        seg_s1_q, seg_s2_q, seg_prev_q;
    logic [NDIG-1:0]   en_s1_q, en_s2_q, en_prev_q;
    logic [7:0]        seg_n;
    logic [NDIG-1:0]   en_n;
    logic              changed, en_one, en_none;
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              capture, set_err_en;
    logic              legal;
    logic [3:0]        nibble;
    logic [NDIG-1:0]   cap_mask, frame_q, frame_d;
    logic              frame_all;
    logic [4*NDIG-1:0] digits_q;
    logic [NDIG-1:0]   dp_q, valid_q;
    logic              stb_q, err_pat_q, err_en_q;

    // Sync flops reset to the idle bus level so release does not look like a selection.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= SegIdle;
            seg_s2_q   <= SegIdle;
            en_s1_q    <= EnIdle;
            en_s2_q    <= EnIdle;
            seg_prev_q <= '0;
            en_prev_q  <= '0;
        end else begin
            seg_s1_q   <= bus.seg;
            seg_s2_q   <= seg_s1_q;
            en_s1_q    <= bus.en;
            en_s2_q    <= en_s1_q;
            seg_prev_q <= seg_n;
            en_prev_q  <= en_n;
        end
    end

    assign seg_n   = seg_s2_q ^ SegIdle;
    assign en_n    = en_s2_q ^ EnIdle;
    assign changed = (seg_n != seg_prev_q) || (en_n != en_prev_q);
    assign en_none = (en_n == '0);
    assign en_one  = !en_none && ((en_n & (en_n - NDIG'(1))) == '0);

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        set_err_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en_one) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else if (en_none || changed) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    // Multi-select held long enough: flag once, then park until the bus moves.
                    set_err_en = 1'b1;
                    cnt_d      = CntSat;
                end else if (cnt_q < CntLast) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSettle: begin
                if (changed) begin
                    cnt_d   = '0;
                    state_d = en_one ? StSettle : StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StCapture;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCapture, StHold: begin
                capture = (state_q == StCapture);
                // A change arriving during the capture cycle is honoured straight away.
                if (changed) begin
                    cnt_d   = '0;
                    state_d = en_one ? StSettle : StIdle;
                end else begin
                    state_d = StHold;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // seg_prev_q/en_prev_q hold the settled value throughout the capture cycle.
    seg7_to_hex u_dec (
        .pat_i    (seg_prev_q[6:0]),
        .legal_o  (legal),
        .nibble_o (nibble)
    );

    assign cap_mask  = capture ? en_prev_q : '0;
    assign frame_d   = frame_q | cap_mask;
    assign frame_all = &frame_d;

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= '0;
            dp_q      <= '0;
            valid_q   <= '0;
            frame_q   <= '0;
            stb_q     <= 1'b0;
            err_pat_q <= 1'b0;
            err_en_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (cap_mask[i] && legal) begin
                    digits_q[4*i +: 4] <= nibble;
                    dp_q[i]            <= seg_prev_q[SEG_DP_BIT];
                end
            end
            if (bus.clear) begin
                valid_q   <= '0;
                frame_q   <= '0;
                stb_q     <= 1'b0;
                err_pat_q <= 1'b0;
                err_en_q  <= 1'b0;
            end else begin
                valid_q <= valid_q | cap_mask;
                frame_q <= frame_all ? '0 : frame_d;
                stb_q   <= frame_all;
                if (capture && !legal) err_pat_q <= 1'b1;
                if (set_err_en)        err_en_q  <= 1'b1;
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.dp          = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_stb   = stb_q;
    assign bus.err_pattern = err_pat_q;
    assign bus.err_enable  = err_en_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a step-level reference model.
module tb_seg_scan_decoder;

    localparam int unsigned NDIG = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_decoder_if #(.NDIG(NDIG)) bus ();

    seg_scan_decoder #(
        .NDIG          (NDIG),
        .SETTLE_CYCLES (4),
        .SEG_ACT_LOW   (1'b1),
        .EN_ACT_LOW    (1'b1)
    ) dut (
        .cin   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Hex glyphs, active high, a = bit 0.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_chk = 0;
    int n_fail = 0;
    int stb_cnt = 0;
    int step_cyc = 0;
    bit chk_on = 1'b0;
    bit step_short = 1'b0;

    // Model: outcome of each held input value, not cycle timing.
    logic [3:0]  m_dig [3];
    logic [2:0]  m_dp, m_valid, m_seen;
    logic        m_errp, m_erre;
    int          m_stb = 0;
    logic [10:0] prev_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_dig[i] = 4'h0;
        m_dp = '0; m_valid = '0; m_seen = '0; m_errp = 1'b0; m_erre = 1'b0;
        prev_v = {8'hFF, 3'b111};
    endtask

    task automatic model_clear();
        m_valid = '0; m_seen = '0; m_errp = 1'b0; m_erre = 1'b0;
    endtask

    // A value held >= 12 cycles that differs from the previous value takes effect.
    task automatic model_apply(input logic [7:0] s, input logic [2:0] e, input int n);
        logic [7:0] hs;
        logic [2:0] he;
        int         idx, nsel;
        logic       legal;
        logic [3:0] nib;
        if ({s, e} != prev_v && n >= 12) begin
            hs = ~s; he = ~e; nsel = 0; idx = 0;
            for (int i = 0; i < 3; i++) if (he[i]) begin nsel++; idx = i; end
            if (nsel == 1) begin
                legal = 1'b0; nib = 4'h0;
                for (int g = 0; g < 16; g++)
                    if (glyph[g] == hs[6:0]) begin legal = 1'b1; nib = 4'(g); end
                if (legal) begin
                    m_dig[idx] = nib;
                    m_dp[idx]  = hs[7];
                end else begin
                    m_errp = 1'b1;
                end
                m_valid[idx] = 1'b1;
                m_seen[idx]  = 1'b1;
                if (&m_seen) begin m_stb++; m_seen = '0; end
            end else if (nsel > 1) begin
                m_erre = 1'b1;
            end
        end
        prev_v = {s, e};
    endtask

    task automatic begin_step(input logic [7:0] s, input logic [2:0] e, input int n);
        bus.seg = s;
        bus.en  = e;
        model_apply(s, e, n);
        step_cyc   = 0;
        step_short = (n < 12);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            step_cyc++;
        end
    endtask

    task automatic step(input logic [7:0] s, input logic [2:0] e, input int n);
        begin_step(s, e, n);
        run(n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".digits"}, 32'(bus.digits), 32'h0);
        chk({tag, ".dp"}, 32'(bus.dp), 32'h0);
        chk({tag, ".valid"}, 32'(bus.digit_valid), 32'h0);
        chk({tag, ".stb"}, 32'(bus.frame_stb), 32'h0);
        chk({tag, ".errp"}, 32'(bus.err_pattern), 32'h0);
        chk({tag, ".erre"}, 32'(bus.err_enable), 32'h0);
    endtask

    // Compare process: every cycle once the current held value has had time to settle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.frame_stb === 1'b1) stb_cnt++;
        if (chk_on && (step_short || step_cyc >= 12)) begin
            chk("digits", 32'(bus.digits), 32'({m_dig[2], m_dig[1], m_dig[0]}));
            chk("dp", 32'(bus.dp), 32'(m_dp));
            chk("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
            chk("err_pattern", 32'(bus.err_pattern), 32'(m_errp));
            chk("err_enable", 32'(bus.err_enable), 32'(m_erre));
            chk("frame_stb_count", 32'(stb_cnt), 32'(m_stb));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // T1: reset with a digit already presented
        rst_n     = 1'b0;
        bus.seg   = 8'hC0;
        bus.en    = 3'b110;
        bus.clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("t1_reset");
        rst_n  = 1'b1;
        chk_on = 1'b1;
        begin_step(8'hC0, 3'b110, 16);
        run(6);
        chk("t1_no_early_capture", 32'(bus.digit_valid), 32'h0);
        run(10);
        chk("t1_digit0", 32'(bus.digits), 32'h000);

        // T2: scan 0,1,A
        step(8'hC0, 3'b110, 16);
        step(8'hF9, 3'b101, 16);
        step(8'h88, 3'b011, 16);
        chk("t2_digits", 32'(bus.digits), 32'hA10);
        chk("t2_valid", 32'(bus.digit_valid), 32'h7);
        chk("t2_one_strobe", 32'(stb_cnt), 32'd1);

        // T3: enable toggling faster than the settle window
        for (int r = 0; r < 2; r++) begin
            step(8'hC0, 3'b110, 3);
            step(8'hC0, 3'b101, 3);
            step(8'hC0, 3'b011, 3);
        end
        step(8'hC0, 3'b111, 16);
        chk("t3_no_strobe", 32'(stb_cnt), 32'd1);
        chk("t3_no_errp", 32'(bus.err_pattern), 32'h0);
        chk("t3_no_erre", 32'(bus.err_enable), 32'h0);

        // T4: '8' with dp, then an illegal glyph
        step(8'h00, 3'b110, 16);
        chk("t4_digit8", 32'(bus.digits[3:0]), 32'h8);
        chk("t4_dp", 32'(bus.dp[0]), 32'h1);
        step(8'hF6, 3'b110, 16);
        chk("t4_errp", 32'(bus.err_pattern), 32'h1);
        chk("t4_held", 32'(bus.digits[3:0]), 32'h8);

        // T5: two digits selected, then clear
        step(8'hC0, 3'b100, 16);
        chk("t5_erre", 32'(bus.err_enable), 32'h1);
        chk("t5_valid_kept", 32'(bus.digit_valid), 32'h7);
        step(8'hC0, 3'b111, 16);
        chk_on    = 1'b0;
        bus.clear = 1'b1;
        @(posedge clk);
        #2;
        bus.clear = 1'b0;
        model_clear();
        run(2);
        chk("t5_clear_erre", 32'(bus.err_enable), 32'h0);
        chk("t5_clear_valid", 32'(bus.digit_valid), 32'h0);
        chk("t5_digits_kept", 32'(bus.digits), 32'hA18);
        chk_on = 1'b1;

        // T6: asynchronous reset while settling
        begin_step(8'hF9, 3'b110, 16);
        run(4);
        #1;
        chk_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_all_zero("t6_async");
        bus.seg = 8'hFF;
        bus.en  = 3'b111;
        model_reset();
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_on = 1'b1;
        step(8'hFF, 3'b111, 16);
        step(8'hF9, 3'b110, 16);
        chk("t6_recover_digits", 32'(bus.digits), 32'h001);
        chk("t6_recover_valid", 32'(bus.digit_valid), 32'h1);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
